// File: rtl/deco7seg_pkg.sv
// Shared types and the active-high hex-to-segment table for the multiplexed 7-segment driver.
package deco7seg_pkg;

    typedef logic [6:0] seg7_t;  // {g,f,e,d,c,b,a}

    localparam seg7_t SEG_APAGADO = 7'b0;

    localparam seg7_t SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,  // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,  // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,  // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71   // C d E F
    };

endpackage

// File: rtl/deco_hex_7seg.sv
// Combinational nibble to active-high segment pattern lookup.
module deco_hex_7seg
    import deco7seg_pkg::*;
(
    input  logic [3:0] nib,
    output seg7_t      seg
);

    assign seg = SEG_HEX[nib];

endmodule

// File: rtl/deco7seg_mux.sv
// Multiplexed N-digit 7-segment driver: display register, refresh prescaler, scan index,
// leading-zero blanking and a registered, polarity-corrected output stage.
module deco7seg_mux
    import deco7seg_pkg::*;
#(
    parameter int N_DIGITOS       = 4,
    parameter int CICLOS_REFRESCO = 50000,
    parameter bit ACTIVO_BAJO     = 1'b1
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [4*N_DIGITOS-1:0]                         valor,
    input  logic                                           cargar,
    input  logic                                           habilitar,
    input  logic                                           blank_ceros,
    output seg7_t                                          seg,
    output logic [N_DIGITOS-1:0]                           anodo,
    output logic [((N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1)-1:0] digito_act
);

    localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
    localparam int PW = $clog2(CICLOS_REFRESCO + 1);
    localparam int DW = 4 * N_DIGITOS;

    // XOR masks: the only place where board polarity enters the design
    localparam seg7_t                SEG_POL = ACTIVO_BAJO ? '1 : '0;
    localparam logic [N_DIGITOS-1:0] AN_POL  = ACTIVO_BAJO ? '1 : '0;

    if (N_DIGITOS < 1 || N_DIGITOS > 8 || CICLOS_REFRESCO < 1) begin : g_param_chk
        $fatal(1, "deco7seg_mux: N_DIGITOS must be 1..8 and CICLOS_REFRESCO >= 1");
    end

    logic [PW-1:0]        presc;
    logic [DW-1:0]        disp;
    logic [3:0]           nib;
    logic [N_DIGITOS-1:0] an_raw;
    logic [N_DIGITOS-1:0] an_nxt;
    logic                 zero_hi;
    seg7_t                seg_dec;
    seg7_t                seg_raw;

    // Select the lit digit's nibble and anode; zero_hi means this digit and all above it are 0
    always_comb begin
        nib     = 4'h0;
        an_raw  = '0;
        zero_hi = 1'b0;
        for (int k = 0; k < N_DIGITOS; k++) begin
            if (digito_act == IW'(k)) begin
                nib       = disp[4*k +: 4];
                an_raw[k] = 1'b1;
                zero_hi   = ((disp >> (4*k)) == '0);
            end
        end
    end

    deco_hex_7seg u_deco (
        .nib (nib),
        .seg (seg_dec)
    );

    // Blank digits keep their anode asserted so the scan duty stays uniform
    always_comb begin
        seg_raw = seg_dec;
        an_nxt  = an_raw;
        if (blank_ceros && digito_act != '0 && zero_hi) begin
            seg_raw = SEG_APAGADO;
        end
        if (!habilitar) begin
            seg_raw = SEG_APAGADO;
            an_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            digito_act <= '0;
            disp       <= '0;
            seg        <= SEG_APAGADO ^ SEG_POL;
            anodo      <= AN_POL;
        end else begin
            if (cargar) begin
                disp <= valor;
            end
            if (presc == PW'(CICLOS_REFRESCO - 1)) begin
                presc      <= '0;
                // explicit wrap so non-power-of-2 digit counts never select a missing digit
                digito_act <= (digito_act == IW'(N_DIGITOS - 1)) ? '0 : digito_act + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
            seg   <= seg_raw ^ SEG_POL;
            anodo <= an_nxt ^ AN_POL;
        end
    end

endmodule

// File: tb/tb_deco7seg_mux.sv
// Scoreboard bench: stimulus pushes expected outputs per cycle, a negedge monitor pops and compares.
module tb_deco7seg_mux;
    import deco7seg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 4 digits, 4 cycles per digit, active-low
    logic        rst, cargar, habilitar, blank_ceros;
    logic [15:0] valor;
    seg7_t       seg;
    logic [3:0]  anodo;
    logic [1:0]  digito_act;

    // DUT B: 3 digits, 1 cycle per digit, active-low
    logic        rst_b, cargar_b, hab_b, blank_b;
    logic [11:0] valor_b;
    seg7_t       seg_b;
    logic [2:0]  anodo_b;
    logic [1:0]  digito_act_b;

    deco7seg_mux #(.N_DIGITOS(4), .CICLOS_REFRESCO(4), .ACTIVO_BAJO(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .valor(valor), .cargar(cargar), .habilitar(habilitar),
        .blank_ceros(blank_ceros), .seg(seg), .anodo(anodo), .digito_act(digito_act)
    );

    deco7seg_mux #(.N_DIGITOS(3), .CICLOS_REFRESCO(1), .ACTIVO_BAJO(1'b1)) u_dut_b (
        .clk(clk), .rst(rst_b), .valor(valor_b), .cargar(cargar_b), .habilitar(hab_b),
        .blank_ceros(blank_b), .seg(seg_b), .anodo(anodo_b), .digito_act(digito_act_b)
    );

    typedef struct {
        string      tag;
        int         cyc;
        bit         dut_b;
        logic [6:0] seg;
        logic [3:0] an;
        logic [1:0] idx;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0 = 0;
    logic [15:0] m_disp = 16'h0;

    // active-low {g..a} patterns, worked out by hand
    localparam logic [6:0] HEX_AL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [15:0] HEX_VALS [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : monitor
        exp_t       e;
        logic [6:0] a_seg;
        logic [3:0] a_an;
        logic [1:0] a_idx;
        forever begin
            @(negedge clk);
            if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.dut_b) begin
                    a_seg = seg_b; a_an = {1'b0, anodo_b}; a_idx = digito_act_b;
                end else begin
                    a_seg = seg; a_an = anodo; a_idx = digito_act;
                end
                checks++;
                if (e.cyc != cyc || a_seg !== e.seg || a_an !== e.an || a_idx !== e.idx) begin
                    errors++;
                    $display("FAIL %s cyc=%0d(exp cyc %0d): got seg=%b an=%b idx=%0d, want seg=%b an=%b idx=%0d",
                             e.tag, cyc, e.cyc, a_seg, a_an, a_idx, e.seg, e.an, e.idx);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(string tag, bit b, logic [6:0] s, logic [3:0] a, logic [1:0] i);
        exp_t x;
        x.tag = tag; x.cyc = cyc; x.dut_b = b; x.seg = s; x.an = a; x.idx = i;
        sb.push_back(x);
    endtask

    function automatic logic [6:0] want_seg(logic [15:0] v, bit bl, int d);
        if (bl && d > 0 && (v >> (4*d)) == 16'h0) return 7'b1111111;
        return HEX_AL[v[4*d +: 4]];
    endfunction

    // One clock on DUT A; expectation uses the register contents and inputs seen before the edge
    task automatic step_a(string tag);
        logic [15:0] v;
        logic [3:0]  an;
        bit          bl, en;
        int          k, d;
        v = m_disp; bl = blank_ceros; en = habilitar;
        if (cargar) m_disp = valor;
        tick();
        k  = cyc - t0;
        d  = ((k - 1) / 4) % 4;
        an = ~(4'b0001 << d);
        if (en) push(tag, 1'b0, want_seg(v, bl, d), an, 2'((k / 4) % 4));
        else    push(tag, 1'b0, 7'b1111111, 4'b1111, 2'((k / 4) % 4));
    endtask

    task automatic reset_a(int n);
        rst = 1'b1;
        cargar = 1'b0;
        repeat (n) tick();
        push("reset_a", 1'b0, 7'b1111111, 4'b1111, 2'd0);
        t0 = cyc;
        m_disp = 16'h0;
        rst = 1'b0;
    endtask

    task automatic load_a(logic [15:0] v, string tag);
        valor = v;
        cargar = 1'b1;
        step_a(tag);
        cargar = 1'b0;
    endtask

    initial begin : stim
        logic [6:0] tab_b [3];
        logic [2:0] an3;
        int         d;
        tab_b = '{7'b1111000, 7'b0001000, 7'b0010010};  // digits of 12'h5A7: 7, A, 5

        rst = 1'b1; cargar = 1'b0; valor = '0; habilitar = 1'b0; blank_ceros = 1'b0;
        rst_b = 1'b1; cargar_b = 1'b0; valor_b = '0; hab_b = 1'b1; blank_b = 1'b0;

        reset_a(2);

        habilitar = 1'b1;
        load_a(16'hDA57, "scan_load");
        repeat (19) step_a("scan_da57");

        foreach (HEX_VALS[i]) begin
            load_a(HEX_VALS[i], "hex_load");
            repeat (15) step_a("hex_scan");
        end

        blank_ceros = 1'b1;
        load_a(16'h0050, "blank_load");
        repeat (16) step_a("blank_0050");
        load_a(16'h1000, "blank_load");
        repeat (16) step_a("blank_1000");
        load_a(16'h0000, "blank_load");
        repeat (16) step_a("blank_0000");

        blank_ceros = 1'b0;
        load_a(16'hDA57, "reload");
        repeat (5) step_a("reload_scan");
        habilitar = 1'b0;
        repeat (4) step_a("disabled");
        habilitar = 1'b1;
        repeat (8) step_a("reenabled");

        // advance until digit 2 is on the pins, then reset mid-scan
        for (int n = 0; n < 16 && ((cyc - t0 - 1) / 4) % 4 != 2; n++) step_a("pre_reset");
        reset_a(1);
        repeat (6) step_a("post_reset");

        // DUT B: every-cycle scan over three digits
        tick();
        push("reset_b", 1'b1, 7'b1111111, 4'b0111, 2'd0);
        rst_b = 1'b0; valor_b = 12'h5A7; cargar_b = 1'b1;
        tick();
        cargar_b = 1'b0;
        push("b_first", 1'b1, 7'b1000000, 4'b0110, 2'd1);
        for (int k = 2; k <= 10; k++) begin
            tick();
            d   = (k - 1) % 3;
            an3 = ~(3'b001 << d);
            push("b_scan", 1'b1, tab_b[d], {1'b0, an3}, 2'(k % 3));
        end

        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
